// File: rtl/imm_gen_pipe_if.sv
// Valid/ready bus of the immediate generator: instruction in, decoded immediate out.
// The design is the slave; the fetch/ID-EX side is the master.
interface imm_gen_pipe_if #(
    parameter int XLEN = 32
) ();
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     instruction;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] imm;
    logic [2:0]      imm_fmt;
    logic            illegal;

    modport master (
        output in_valid, instruction, out_ready,
        input  in_ready, out_valid, imm, imm_fmt, illegal
    );

    modport slave (
        input  in_valid, instruction, out_ready,
        output in_ready, out_valid, imm, imm_fmt, illegal
    );
endinterface

// File: rtl/imm_gen_pipe.sv
// Decode-stage immediate generator: combinational RV32/RV64 immediate decode feeding
// a 2-entry skid FIFO, with flush and a saturating illegal-opcode counter.
module imm_gen_pipe #(
    parameter int XLEN      = 32,
    parameter int ILL_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    imm_gen_pipe_if.slave        bus,
    output logic [ILL_CNT_W-1:0] ill_count
);

    typedef enum logic [2:0] {
        FMT_NONE  = 3'd0,
        FMT_I     = 3'd1,
        FMT_S     = 3'd2,
        FMT_B     = 3'd3,
        FMT_U     = 3'd4,
        FMT_J     = 3'd5,
        FMT_SHAMT = 3'd6,
        FMT_CSR   = 3'd7
    } fmt_e;

    typedef struct packed {
        logic [XLEN-1:0] imm;
        logic [2:0]      fmt;
        logic            ill;
    } entry_t;

    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;

    localparam logic [ILL_CNT_W-1:0] ILL_MAX = {ILL_CNT_W{1'b1}};

    logic [31:0] ins;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        is_shift;
    entry_t      dec;

    logic [1:0]           count_q, count_d;
    entry_t               ent0_q, ent0_d;
    entry_t               ent1_q, ent1_d;
    logic [ILL_CNT_W-1:0] ill_cnt_q, ill_cnt_d;
    logic                 push;
    logic                 pop;

    assign ins      = bus.instruction;
    assign opcode   = ins[6:0];
    assign funct3   = ins[14:12];
    assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);

    // Every immediate is built at its natural width and then size-cast to XLEN.
    always_comb begin
        dec.imm = '0;
        dec.fmt = FMT_NONE;
        dec.ill = 1'b0;
        unique case (opcode)
            OPC_OP_IMM: begin
                if (is_shift) begin
                    dec.fmt = FMT_SHAMT;
                    dec.imm = (XLEN == 64) ? XLEN'(ins[25:20]) : XLEN'(ins[24:20]);
                end else begin
                    dec.fmt = FMT_I;
                    dec.imm = XLEN'($signed(ins[31:20]));
                end
            end
            OPC_LOAD, OPC_JALR: begin
                dec.fmt = FMT_I;
                dec.imm = XLEN'($signed(ins[31:20]));
            end
            OPC_STORE: begin
                dec.fmt = FMT_S;
                dec.imm = XLEN'($signed({ins[31:25], ins[11:7]}));
            end
            OPC_BRANCH: begin
                dec.fmt = FMT_B;
                dec.imm = XLEN'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
            end
            OPC_JAL: begin
                dec.fmt = FMT_J;
                dec.imm = XLEN'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
            end
            OPC_LUI, OPC_AUIPC: begin
                dec.fmt = FMT_U;
                dec.imm = XLEN'($signed({ins[31:12], 12'b0}));
            end
            OPC_SYSTEM: begin
                if (funct3[2] && (funct3[1:0] != 2'b00)) begin
                    dec.fmt = FMT_CSR;
                    dec.imm = XLEN'(ins[19:15]);
                end
            end
            OPC_OP, OPC_MISC_MEM: begin
                dec.fmt = FMT_NONE;
            end
            OPC_OP_IMM_32: begin
                if (XLEN != 64) begin
                    dec.ill = 1'b1;
                end else if (is_shift) begin
                    dec.fmt = FMT_SHAMT;
                    dec.imm = XLEN'(ins[24:20]);
                end else begin
                    dec.fmt = FMT_I;
                    dec.imm = XLEN'($signed(ins[31:20]));
                end
            end
            OPC_OP_32: begin
                dec.ill = (XLEN != 64);
            end
            default: begin
                dec.ill = 1'b1;
            end
        endcase
    end

    assign bus.in_ready  = (count_q != 2'd2);
    assign bus.out_valid = (count_q != 2'd0);
    assign push          = bus.in_valid & bus.in_ready;
    assign pop           = bus.out_valid & bus.out_ready;

    // Flush wins over push/pop; entry 0 is always the head, so a pop shifts entry 1 down.
    always_comb begin
        count_d   = count_q;
        ent0_d    = ent0_q;
        ent1_d    = ent1_q;
        ill_cnt_d = ill_cnt_q;
        if (flush) begin
            count_d = 2'd0;
        end else begin
            if (push && dec.ill && (ill_cnt_q != ILL_MAX)) begin
                ill_cnt_d = ill_cnt_q + 1'b1;
            end
            unique case ({push, pop})
                2'b10: begin
                    if (count_q == 2'd0) begin
                        ent0_d = dec;
                    end else begin
                        ent1_d = dec;
                    end
                    count_d = count_q + 2'd1;
                end
                2'b01: begin
                    ent0_d  = ent1_q;
                    count_d = count_q - 2'd1;
                end
                2'b11: begin
                    // Not full, so count is 1: the head leaves and the new entry becomes head.
                    ent0_d = dec;
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q   <= 2'd0;
            ent0_q    <= '0;
            ent1_q    <= '0;
            ill_cnt_q <= '0;
        end else begin
            count_q   <= count_d;
            ent0_q    <= ent0_d;
            ent1_q    <= ent1_d;
            ill_cnt_q <= ill_cnt_d;
        end
    end

    assign bus.imm     = bus.out_valid ? ent0_q.imm : '0;
    assign bus.imm_fmt = bus.out_valid ? ent0_q.fmt : 3'd0;
    assign bus.illegal = bus.out_valid & ent0_q.ill;
    assign ill_count   = ill_cnt_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: XLEN=32 and XLEN=64 instances share one stimulus stream and
// are checked every cycle against a queue-based reference plus hand-computed vectors.
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic [31:0] instruction;
    logic        out_ready;
    logic [2:0]  ill32;
    logic [15:0] ill64;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    imm_gen_pipe_if #(.XLEN(32)) if32 ();
    imm_gen_pipe_if #(.XLEN(64)) if64 ();

    assign if32.in_valid    = in_valid;
    assign if32.instruction = instruction;
    assign if32.out_ready   = out_ready;
    assign if64.in_valid    = in_valid;
    assign if64.instruction = instruction;
    assign if64.out_ready   = out_ready;

    imm_gen_pipe #(.XLEN(32), .ILL_CNT_W(3)) u32 (
        .clk(clk), .rst(rst), .flush(flush), .bus(if32), .ill_count(ill32)
    );
    imm_gen_pipe #(.XLEN(64), .ILL_CNT_W(16)) u64 (
        .clk(clk), .rst(rst), .flush(flush), .bus(if64), .ill_count(ill64)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference decoder written as plain integer arithmetic on the instruction fields.
    function automatic void ref_decode(input logic [31:0] ins, input bit x64,
                                       output logic [63:0] imm, output logic [2:0] fmt,
                                       output bit ill);
        longint     v;
        longint     base;
        logic [2:0] f3;
        v    = 0;
        base = longint'($signed(ins));
        f3   = ins[14:12];
        fmt  = 3'd0;
        ill  = 1'b0;
        case (ins[6:0])
            7'h13: if (f3 == 3'd1 || f3 == 3'd5) begin
                fmt = 3'd6;
                v   = x64 ? longint'(ins[25:20]) : longint'(ins[24:20]);
            end else begin
                fmt = 3'd1;
                v   = base >>> 20;
            end
            7'h03, 7'h67: begin fmt = 3'd1; v = base >>> 20; end
            7'h23: begin fmt = 3'd2; v = (base >>> 25) * 32 + longint'(ins[11:7]); end
            7'h63: begin
                fmt = 3'd3;
                v = (ins[31] ? -4096 : 0) + longint'(ins[7]) * 2048
                    + longint'(ins[30:25]) * 32 + longint'(ins[11:8]) * 2;
            end
            7'h6F: begin
                fmt = 3'd5;
                v = (ins[31] ? -(1 << 20) : 0) + longint'(ins[19:12]) * 4096
                    + longint'(ins[20]) * 2048 + longint'(ins[30:21]) * 2;
            end
            7'h37, 7'h17: begin fmt = 3'd4; v = (base >>> 12) * 4096; end
            7'h73: if (f3 >= 3'd5) begin fmt = 3'd7; v = longint'(ins[19:15]); end
            7'h33, 7'h0F: ;
            7'h1B: if (!x64) ill = 1'b1;
                   else if (f3 == 3'd1 || f3 == 3'd5) begin fmt = 3'd6; v = longint'(ins[24:20]); end
                   else begin fmt = 3'd1; v = base >>> 20; end
            7'h3B: if (!x64) ill = 1'b1;
            default: ill = 1'b1;
        endcase
        imm = 64'(v);
    endfunction

    typedef struct {
        logic [63:0] imm;
        logic [2:0]  fmt;
        bit          ill;
    } ent_t;

    ent_t   mq [2][$];
    longint mc [2];
    longint mmax [2] = '{7, 65535};
    bit     mdl_on = 1'b0;

    always @(posedge clk) begin
        bit   can_push;
        bit   do_push;
        bit   do_pop;
        ent_t e;
        if (rst) begin
            for (int x = 0; x < 2; x++) begin
                mq[x].delete();
                mc[x] = 0;
            end
            mdl_on = 1'b1;
        end else if (mdl_on) begin
            for (int x = 0; x < 2; x++) begin
                can_push = (mq[x].size() != 2);
                do_push  = in_valid && can_push;
                do_pop   = (mq[x].size() != 0) && out_ready;
                if (flush) begin
                    mq[x].delete();
                end else begin
                    ref_decode(instruction, (x == 1), e.imm, e.fmt, e.ill);
                    if (do_push && e.ill && mc[x] < mmax[x]) mc[x]++;
                    if (do_pop) void'(mq[x].pop_front());
                    if (do_push) mq[x].push_back(e);
                end
            end
        end
    end

    always @(negedge clk) begin
        logic [63:0] ei;
        logic [2:0]  ef;
        bit          el;
        if (mdl_on) begin
            for (int x = 0; x < 2; x++) begin
                ei = 64'd0; ef = 3'd0; el = 1'b0;
                if (mq[x].size() != 0) begin
                    ei = mq[x][0].imm; ef = mq[x][0].fmt; el = mq[x][0].ill;
                end
                if (x == 0) begin
                    chk("m32_out_valid", 64'(if32.out_valid), 64'(mq[0].size() != 0));
                    chk("m32_in_ready",  64'(if32.in_ready),  64'(mq[0].size() != 2));
                    chk("m32_imm",       64'(if32.imm),       {32'd0, ei[31:0]});
                    chk("m32_fmt",       64'(if32.imm_fmt),   64'(ef));
                    chk("m32_illegal",   64'(if32.illegal),   64'(el));
                    chk("m32_ill_count", 64'(ill32),          64'(mc[0]));
                end else begin
                    chk("m64_out_valid", 64'(if64.out_valid), 64'(mq[1].size() != 0));
                    chk("m64_in_ready",  64'(if64.in_ready),  64'(mq[1].size() != 2));
                    chk("m64_imm",       if64.imm,            ei);
                    chk("m64_fmt",       64'(if64.imm_fmt),   64'(ef));
                    chk("m64_illegal",   64'(if64.illegal),   64'(el));
                    chk("m64_ill_count", 64'(ill64),          64'(mc[1]));
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push1(input logic [31:0] ins);
        instruction = ins;
        in_valid    = 1'b1;
        step();
        in_valid    = 1'b0;
    endtask

    task automatic lit(input string name, input logic [63:0] i32, input logic [2:0] f32,
                       input logic [63:0] i64, input logic [2:0] f64);
        chk({name, "_v32"},   64'(if32.out_valid), 64'd1);
        chk({name, "_imm32"}, 64'(if32.imm),       i32);
        chk({name, "_fmt32"}, 64'(if32.imm_fmt),   64'(f32));
        chk({name, "_v64"},   64'(if64.out_valid), 64'd1);
        chk({name, "_imm64"}, if64.imm,            i64);
        chk({name, "_fmt64"}, 64'(if64.imm_fmt),   64'(f64));
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; instruction = 32'h0; out_ready = 1'b1;
        step(); step();
        rst = 1'b0;
        chk("rst_out_valid", 64'(if32.out_valid), 64'd0);
        chk("rst_in_ready",  64'(if64.in_ready),  64'd1);
        chk("rst_ill_count", 64'(ill64),          64'd0);

        push1(32'hFFF00093);
        lit("addi_m1", 64'hFFFFFFFF, 3'd1, 64'hFFFFFFFFFFFFFFFF, 3'd1);
        push1(32'h4030D093);
        lit("srai3", 64'h3, 3'd6, 64'h3, 3'd6);
        push1(32'hFFDFF06F);
        lit("jal_m4", 64'hFFFFFFFC, 3'd5, 64'hFFFFFFFFFFFFFFFC, 3'd5);
        push1(32'h800000B7);
        lit("lui", 64'h80000000, 3'd4, 64'hFFFFFFFF80000000, 3'd4);
        push1(32'hFE000EE3);
        lit("beq_m4", 64'hFFFFFFFC, 3'd3, 64'hFFFFFFFFFFFFFFFC, 3'd3);
        push1(32'h0250D093);
        lit("srli37", 64'h5, 3'd6, 64'd37, 3'd6);
        push1(32'h300FD073);
        lit("csrrwi", 64'h1F, 3'd7, 64'h1F, 3'd7);
        chk("csr_illegal", 64'(if32.illegal), 64'd0);
        push1(32'h0000007F);
        chk("ill_flag", 64'(if64.illegal), 64'd1);
        chk("ill_imm",  if64.imm,          64'd0);
        chk("ill_cnt1", 64'(ill32),        64'd1);
        push1(32'h0010101B);
        chk("w_ill32", 64'(if32.illegal), 64'd1);
        chk("w_imm64", if64.imm,          64'd1);
        chk("w_cnt32", 64'(ill32),        64'd2);
        chk("w_cnt64", 64'(ill64),        64'd1);
        foreach (instruction[i]) if (i == 0) push1(32'hFE112E23);
        push1(32'h00000033);
        step();

        // Back-pressure: third offer must wait until the consumer drains.
        out_ready = 1'b0;
        push1(32'h00100093);
        push1(32'h00200093);
        instruction = 32'h00300093; in_valid = 1'b1;
        step();
        chk("full_in_ready", 64'(if32.in_ready), 64'd0);
        chk("full_head",     64'(if64.imm),      64'd1);
        out_ready = 1'b1;
        step();
        chk("drain_b", 64'(if32.imm), 64'd2);
        step();
        in_valid = 1'b0;
        chk("drain_c", 64'(if32.imm), 64'd3);
        step();
        chk("drain_empty", 64'(if32.out_valid), 64'd0);

        // Flush while full, then flush with one entry and a legal offer.
        out_ready = 1'b0;
        push1(32'h00100093);
        push1(32'h00200093);
        instruction = 32'h0000007F; in_valid = 1'b1; flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_valid", 64'(if64.out_valid), 64'd0);
        chk("flush_cnt32", 64'(ill32),          64'd2);
        push1(32'h00500093);
        instruction = 32'h00600093; in_valid = 1'b1; flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush1_valid", 64'(if32.out_valid), 64'd0);

        push1(32'hFFF00093);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst2_valid",    64'(if64.out_valid), 64'd0);
        chk("rst2_imm",      if64.imm,            64'd0);
        chk("rst2_in_ready", 64'(if32.in_ready),  64'd1);
        chk("rst2_cnt",      64'(ill32),          64'd0);

        // Saturation of the narrow counter.
        out_ready = 1'b1;
        instruction = 32'h0000007F; in_valid = 1'b1;
        repeat (10) step();
        in_valid = 1'b0;
        chk("sat_cnt32", 64'(ill32), 64'd7);
        chk("sat_cnt64", 64'(ill64), 64'd10);
        step(); step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
